decim_sched: RTL and testbench

DECIM_SCHED -- requirements
Module: decim_sched

---
 rtl/decim_sched_pkg.sv | 14 +
 rtl/decim_chan.sv | 73 +++++++
 rtl/decim_sched.sv | 106 ++++++++++
 tb/tb_decim_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/decim_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decim_sched_pkg
// Brief    : Shared sizes and reset constants for the decimation scheduler.
// Revision : 1.0
// ============================================================================
package decim_sched_pkg;
    localparam int C_NCH         = 4;
    localparam int C_DW          = 16;
    localparam int C_RW          = 8;
    localparam int C_RESET_RATIO = 7;
    localparam int C_CHW         = $clog2(C_NCH);
endpackage
`default_nettype wire

// File: rtl/decim_chan.sv
`default_nettype none
// ============================================================================
// Module   : decim_chan
// Brief    : One decimation channel: phase counter, ratio, hold register, overrun.
// Revision : 1.0
// ============================================================================
module decim_chan
    import decim_sched_pkg::*;
#(
    parameter int DW = C_DW,
    parameter int RW = C_RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_strobe,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_cfg_we,
    input  logic [RW-1:0] i_cfg_data,
    input  logic [DW-1:0] i_din,
    input  logic          i_grant,
    input  logic          i_overrun_clr,
    output logic [DW-1:0] o_hold,
    output logic          o_hv,
    output logic          o_overrun
);
    logic [RW-1:0] r_ratio;
    logic [RW-1:0] r_cnt;
    logic [DW-1:0] r_hold;
    logic          r_hv;
    logic          r_overrun;
    logic          w_capture;

    // sync, config writes and disable all pre-empt a capture this cycle
    assign w_capture = i_strobe && i_en && !i_sync && !i_cfg_we && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ratio   <= RW'(C_RESET_RATIO);
            r_cnt     <= '0;
            r_hold    <= '0;
            r_hv      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_cfg_we)
                r_ratio <= i_cfg_data;

            if (i_sync || i_cfg_we || !i_en)
                r_cnt <= '0;
            else if (i_strobe)
                r_cnt <= (r_cnt == r_ratio) ? '0 : r_cnt + RW'(1);

            if (w_capture)
                r_hold <= i_din;

            // a grant in the same cycle takes the old hold, so hv stays set
            if (w_capture)
                r_hv <= 1'b1;
            else if (i_grant)
                r_hv <= 1'b0;

            if (w_capture && r_hv && !i_grant)
                r_overrun <= 1'b1;
            else if (i_overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign o_hold    = r_hold;
    assign o_hv      = r_hv;
    assign o_overrun = r_overrun;
endmodule
`default_nettype wire

// File: rtl/decim_sched.sv
`default_nettype none
// ============================================================================
// Module   : decim_sched
// Brief    : Multi-channel decimator with round-robin valid/ready output.
// Revision : 1.0
// ============================================================================
module decim_sched
    import decim_sched_pkg::*;
#(
    parameter int NCH = C_NCH,
    parameter int DW  = C_DW,
    parameter int RW  = C_RW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe_in,
    input  logic [NCH*DW-1:0]  datain,
    input  logic [NCH-1:0]     ch_en,
    input  logic               sync,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [RW-1:0]      cfg_data,
    output logic [DW-1:0]      dataout,
    output logic [C_CHW-1:0]   chan_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCH-1:0]     overrun,
    input  logic               overrun_clr
);
    localparam int CHW = C_CHW;
    localparam logic [CHW-1:0] C_LAST_RST = CHW'(NCH - 1);

    logic [DW-1:0]  w_hold [NCH];
    logic [NCH-1:0] w_hv;
    logic [NCH-1:0] w_grant_vec;
    logic [CHW-1:0] w_sel;
    logic [CHW-1:0] w_idx;
    logic           w_found;
    logic           w_grant;

    logic [CHW-1:0] r_last;
    logic [DW-1:0]  r_dataout;
    logic [CHW-1:0] r_chan_id;
    logic           r_out_valid;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            decim_chan #(
                .DW (DW),
                .RW (RW)
            ) u_chan (
                .clk           (clk),
                .reset         (reset),
                .i_strobe      (strobe_in),
                .i_en          (ch_en[i]),
                .i_sync        (sync),
                .i_cfg_we      (cfg_wr && (cfg_addr == 2'(i))),
                .i_cfg_data    (cfg_data),
                .i_din         (datain[i*DW +: DW]),
                .i_grant       (w_grant_vec[i]),
                .i_overrun_clr (overrun_clr),
                .o_hold        (w_hold[i]),
                .o_hv          (w_hv[i]),
                .o_overrun     (overrun[i])
            );
            assign w_grant_vec[i] = w_grant && (w_sel == CHW'(i));
        end
    endgenerate

    // round-robin search starting one past the last granted channel
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = CHW'((int'(r_last) + k) % NCH);
            if (!w_found && w_hv[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_grant = (!r_out_valid || out_ready) && w_found;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last      <= C_LAST_RST;
            r_dataout   <= '0;
            r_chan_id   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_grant) begin
            r_last      <= w_sel;
            r_dataout   <= w_hold[w_sel];
            r_chan_id   <= w_sel;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign dataout   = r_dataout;
    assign chan_id   = r_chan_id;
    assign out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_decim_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_decim_sched
// Brief    : Directed self-checking bench for decim_sched.
// Revision : 1.0
// ============================================================================
module tb_decim_sched;
    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int RW  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              strobe_in = 1'b0;
    logic [NCH*DW-1:0] datain = '0;
    logic [NCH-1:0]    ch_en = '0;
    logic              sync = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_addr = '0;
    logic [RW-1:0]     cfg_data = '0;
    logic              out_ready = 1'b1;
    logic              overrun_clr = 1'b0;
    logic [DW-1:0]     dataout;
    logic [1:0]        chan_id;
    logic              out_valid;
    logic [NCH-1:0]    overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decim_sched #(.NCH(NCH), .DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .strobe_in   (strobe_in),
        .datain      (datain),
        .ch_en       (ch_en),
        .sync        (sync),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .dataout     (dataout),
        .chan_id     (chan_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [RW-1:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (dataout !== 16'h0) begin errors++; $display("FAIL rst_data: got %h expected 0000", dataout); end
        checks++; if (chan_id !== 2'd0) begin errors++; $display("FAIL rst_chan: got %0d expected 0", chan_id); end
        checks++; if (overrun !== 4'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0000", overrun); end
        reset = 1'b1;
        tick();
    endtask

    // default ratio 7: strobe cycles 0, 8, 16 captured, visible 2 cycles later
    task automatic test_decim();
        int nout = 0;
        int exp_t [3] = '{2, 10, 18};
        logic [DW-1:0] exp_d [3] = '{16'd0, 16'd8, 16'd16};
        ch_en = 4'b0001; out_ready = 1'b1;
        for (int k = 0; k < 21; k++) begin
            strobe_in = 1'b1; datain[15:0] = 16'(k);
            tick();
            if (out_valid === 1'b1) begin
                if (nout < 3) begin
                    checks++; if (dataout !== exp_d[nout]) begin errors++; $display("FAIL decim_data: got %0d expected %0d", dataout, exp_d[nout]); end
                    checks++; if (chan_id !== 2'd0) begin errors++; $display("FAIL decim_chan: got %0d expected 0", chan_id); end
                    checks++; if (k + 1 != exp_t[nout]) begin errors++; $display("FAIL decim_time: got cycle %0d expected %0d", k + 1, exp_t[nout]); end
                end
                nout++;
            end
        end
        strobe_in = 1'b0;
        tick();
        checks++; if (nout != 3) begin errors++; $display("FAIL decim_count: got %0d expected 3", nout); end
    endtask

    task automatic test_cfg();
        int nout = 0;
        tick(); tick(); tick();
        ch_en = 4'b0010;
        cfg(2'd1, 8'd0);
        for (int k = 0; k < 12; k++) begin
            strobe_in = (k < 5); datain[31:16] = 16'(100 + k);
            tick();
            if (out_valid === 1'b1) begin
                checks++; if (chan_id !== 2'd1) begin errors++; $display("FAIL cfg_chan: got %0d expected 1", chan_id); end
                checks++; if (dataout !== 16'(100 + nout)) begin errors++; $display("FAIL cfg_data: got %0d expected %0d", dataout, 100 + nout); end
                nout++;
            end
        end
        strobe_in = 1'b0;
        checks++; if (nout != 5) begin errors++; $display("FAIL cfg_count: got %0d expected 5", nout); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_d [4] = '{16'h1000, 16'h1111, 16'h2222, 16'h3333};
        reset = 1'b0; tick(); reset = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cfg(2'(c), 8'd0);
        ch_en = 4'hF;
        datain = {16'h3333, 16'h2222, 16'h1111, 16'h1000};
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_early: got %b expected 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || chan_id !== 2'(i) || dataout !== exp_d[i])
                begin errors++; $display("FAIL rr_slot%0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", i, out_valid, chan_id, dataout, i, exp_d[i]); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_overrun();
        ch_en = 4'b0001; out_ready = 1'b0;
        strobe_in = 1'b1; datain[15:0] = 16'h00A1;
        tick();
        datain[15:0] = 16'h00A2;
        tick();
        // capture coinciding with grant: old value out, no overrun
        checks++; if (out_valid !== 1'b1 || dataout !== 16'h00A1) begin errors++; $display("FAIL ovr_first: got v=%b d=%h expected v=1 d=00a1", out_valid, dataout); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_samecycle: got %b expected 0000", overrun); end
        datain[15:0] = 16'h00A3;
        tick();
        strobe_in = 1'b0;
        checks++; if (overrun !== 4'b0001) begin errors++; $display("FAIL ovr_set: got %b expected 0001", overrun); end
        checks++; if (dataout !== 16'h00A1 || chan_id !== 2'd0) begin errors++; $display("FAIL ovr_hold: got d=%h ch=%0d expected d=00a1 ch=0", dataout, chan_id); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clr: got %b expected 0000", overrun); end
        strobe_in = 1'b1; overrun_clr = 1'b1; datain[15:0] = 16'h00A4;
        tick();
        strobe_in = 1'b0; overrun_clr = 1'b0;
        checks++; if (overrun !== 4'b0001) begin errors++; $display("FAIL ovr_clr_race: got %b expected 0001", overrun); end
        checks++; if (out_valid !== 1'b1 || dataout !== 16'h00A1) begin errors++; $display("FAIL ovr_stable: got v=%b d=%h expected v=1 d=00a1", out_valid, dataout); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL rmid_overrun: got %b expected 0000", overrun); end
        reset = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_discard: got %0d stale outputs expected 0", seen); end
        strobe_in = 1'b1; datain[15:0] = 16'h0055;
        tick();
        strobe_in = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || dataout !== 16'h0055) begin errors++; $display("FAIL rmid_first: got v=%b d=%h expected v=1 d=0055", out_valid, dataout); end
        tick(); tick();
    endtask

    // counter sits at 1 after the previous capture; sync realigns it mid-count
    task automatic test_sync();
        int nout = 0;
        logic [DW-1:0] exp_d [3] = '{16'd50, 16'd58, 16'd66};
        ch_en = 4'b0001; out_ready = 1'b1;
        for (int k = 0; k < 26; k++) begin
            sync = (k == 3);
            strobe_in = (k < 22);
            datain[15:0] = (k < 3) ? 16'(k + 1) : (k == 3) ? 16'd99 : 16'(50 + k - 4);
            tick();
            if (out_valid === 1'b1) begin
                checks++;
                if (nout >= 3) begin errors++; $display("FAIL sync_extra: got d=%0d expected no output", dataout); end
                else if (dataout !== exp_d[nout]) begin errors++; $display("FAIL sync_data: got %0d expected %0d", dataout, exp_d[nout]); end
                nout++;
            end
        end
        sync = 1'b0; strobe_in = 1'b0;
        checks++; if (nout != 3) begin errors++; $display("FAIL sync_count: got %0d expected 3", nout); end
    endtask

    initial begin
        test_reset();
        test_decim();
        test_cfg();
        test_round_robin();
        test_overrun();
        test_reset_mid();
        test_sync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
